// File: rtl/riscv_alu_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_alu_arbiter
//
// Shares one combinational ALU between two requesters. A round-robin grant
// picks one request in IDLE, the operands are captured, driven to the ALU for
// one cycle (EXEC), and the registered result is presented until the consumer
// accepts it (RESP). Only one operation is in flight at a time.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i[1:0]             per-requester request valid
//   req_ready_o[1:0]             per-requester accept (only ever in IDLE)
//   req0_op_i, req1_op_i         requested ALU opcode ([2:0] op, [3] SUB/SRA)
//   req0_a_i/b_i, req1_a_i/b_i   requested operands
//   alu_op_o, alu_a_o, alu_b_o   captured operation driven to the shared ALU
//   alu_result_i                 combinational ALU result
//   rsp_valid_o, rsp_ready_i     response handshake
//   rsp_id_o                     requester that owns the response
//   rsp_result_o                 registered ALU result
// -----------------------------------------------------------------------------
module riscv_alu_arbiter #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] req0_op_i,
    input  logic [ALU_OP_WIDTH-1:0] req1_op_i,
    input  logic [XLEN-1:0]         req0_a_i,
    input  logic [XLEN-1:0]         req0_b_i,
    input  logic [XLEN-1:0]         req1_a_i,
    input  logic [XLEN-1:0]         req1_b_i,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [XLEN-1:0]         alu_a_o,
    output logic [XLEN-1:0]         alu_b_o,
    input  logic [XLEN-1:0]         alu_result_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_id_o,
    output logic [XLEN-1:0]         rsp_result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    id_q, id_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [XLEN-1:0]         a_q, a_d;
    logic [XLEN-1:0]         b_q, b_d;
    logic [XLEN-1:0]         result_q, result_d;

    logic grant_id;
    logic handshake;

    // With both requesters valid, the one that did not win last time wins now;
    // otherwise the single valid requester is chosen (bit 1 tells which).
    always_comb begin
        if (req_valid_i == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid_i[1];
        end
    end

    // Ready is only offered in IDLE and never while reset is asserted, so a
    // requester cannot see an accept that reset is about to discard.
    always_comb begin
        req_ready_o = 2'b00;
        if (state_q == IDLE && !rst_i && (|req_valid_i)) begin
            req_ready_o = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign handshake = |req_ready_o;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    op_d         = grant_id ? req1_op_i : req0_op_i;
                    a_d          = grant_id ? req1_a_i  : req0_a_i;
                    b_d          = grant_id ? req1_b_i  : req0_b_i;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result_i;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
        end
    end

    // The ALU only ever sees the captured registers, never the request ports.
    assign alu_op_o     = op_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
module tb_riscv_alu_arbiter;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [XLEN-1:0] rsp_result;

    int n_vec  = 0;
    int n_fail = 0;

    riscv_alu_arbiter #(.XLEN(XLEN), .ALU_OP_WIDTH(OPW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req0_op_i    (req0_op),
        .req1_op_i    (req1_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared RV32 ALU (funct3-style encoding, bit 3 = SUB/SRA).
    logic signed [XLEN-1:0] sa, sb;
    always_comb begin
        sa = alu_a;
        sb = alu_b;
        alu_result = '0;
        case (alu_op[2:0])
            3'd0: alu_result = alu_op[3] ? alu_a - alu_b : alu_a + alu_b;
            3'd1: alu_result = alu_a << alu_b[4:0];
            3'd2: alu_result = {31'd0, sa < sb};
            3'd3: alu_result = {31'd0, alu_a < alu_b};
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_op[3] ? XLEN'(sa >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
            3'd6: alu_result = alu_a | alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end

    typedef struct {
        logic            port;
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"},  {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rsp_id"},     {63'd0, rsp_id},    64'd0);
        check({tag, "_rsp_result"}, {32'd0, rsp_result}, 64'd0);
        check({tag, "_alu_op"},     {60'd0, alu_op},    64'd0);
        check({tag, "_alu_a"},      {32'd0, alu_a},     64'd0);
        check({tag, "_alu_b"},      {32'd0, alu_b},     64'd0);
    endtask

    // One isolated request: ready at N, ALU drive at N+1, response at N+2.
    task automatic run_one(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        if (v.port) begin
            req1_op = v.op; req1_a = v.a; req1_b = v.b; req_valid = 2'b10;
        end else begin
            req0_op = v.op; req0_a = v.a; req0_b = v.b; req_valid = 2'b01;
        end
        #1 check({t, "_ready"}, {62'd0, req_ready}, v.port ? 64'd2 : 64'd1);
        tick();
        req_valid = 2'b00;
        #1;
        check({t, "_alu_op"}, {60'd0, alu_op}, {60'd0, v.op});
        check({t, "_alu_a"},  {32'd0, alu_a},  {32'd0, v.a});
        check({t, "_alu_b"},  {32'd0, alu_b},  {32'd0, v.b});
        check({t, "_exec_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        tick();
        #1;
        check({t, "_rsp_valid"},  {63'd0, rsp_valid},  64'd1);
        check({t, "_rsp_id"},     {63'd0, rsp_id},     {63'd0, v.port});
        check({t, "_rsp_result"}, {32'd0, rsp_result}, {32'd0, v.res});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1 check({t, "_idle_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //          port  op     a              b              expected result
        vecs[0]  = '{1'b0, 4'h0, 32'd5,         32'd7,         32'd12};
        vecs[1]  = '{1'b1, 4'h8, 32'd3,         32'd10,        32'hFFFF_FFF9};
        vecs[2]  = '{1'b0, 4'h7, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0};
        vecs[3]  = '{1'b1, 4'h6, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001};
        vecs[4]  = '{1'b0, 4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vecs[5]  = '{1'b1, 4'h1, 32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[6]  = '{1'b0, 4'h5, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[7]  = '{1'b1, 4'hD, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[8]  = '{1'b0, 4'h2, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[9]  = '{1'b1, 4'h3, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[10] = '{1'b0, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[11] = '{1'b1, 4'hF, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F};

        rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b11;
        req0_op = 4'h8; req0_a = 32'd3;         req0_b = 32'd10;
        req1_op = 4'h7; req1_a = 32'hFF00_FF00; req1_b = 32'h0FF0_0FF0;

        // Reset: no accept while rst is high, all outputs cleared.
        tick(); tick();
        #1 check("rst_ready", {62'd0, req_ready}, 64'd0);
        check_reset_outputs("rst");
        rst = 1'b0;

        // First contention after reset: port 0 wins, then port 1.
        #1 check("cont_ready0", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b10;
        #1 check("cont_alu_op0", {60'd0, alu_op}, 64'h8);
        tick();
        #1;
        check("cont_rsp_valid0", {63'd0, rsp_valid}, 64'd1);
        check("cont_rsp_id0", {63'd0, rsp_id}, 64'd0);
        check("cont_result0", {32'd0, rsp_result}, 64'hFFFF_FFF9);
        check("cont_resp_ready", {62'd0, req_ready}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1 check("cont_ready1", {62'd0, req_ready}, 64'd2);
        tick();
        req_valid = 2'b00;
        tick();
        #1;
        check("cont_rsp_id1", {63'd0, rsp_id}, 64'd1);
        check("cont_result1", {32'd0, rsp_result}, 64'h0F00_0F00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Sustained contention: grants alternate 0,1,0,1,0,1.
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int w;
            w = 0;
            #1;
            while (req_ready == 2'b00 && w < 8) begin
                tick(); #1; w++;
            end
            check($sformatf("rr%0d_ready", k), {62'd0, req_ready}, (k % 2) ? 64'd2 : 64'd1);
            tick(); tick();
            #1;
            check($sformatf("rr%0d_rsp_valid", k), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("rr%0d_rsp_id", k), {63'd0, rsp_id}, (k % 2) ? 64'd1 : 64'd0);
            tick();
        end
        req_valid = 2'b00; rsp_ready = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_one(i, vecs[i]);
        end

        // Backpressure: response held for 5 cycles, no accepts meanwhile.
        req0_op = 4'h0; req0_a = 32'd100; req0_b = 32'd23; req_valid = 2'b01;
        #1 check("bp_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b11;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d_rsp_valid", c), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("bp%0d_result", c), {32'd0, rsp_result}, 64'd123);
            check($sformatf("bp%0d_id", c), {63'd0, rsp_id}, 64'd0);
            check($sformatf("bp%0d_ready", c), {62'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // Back in IDLE; port 0 won last, so port 1 is offered. Withdraw it.
        #1 check("bp_idle_ready", {62'd0, req_ready}, 64'd2);
        check("bp_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        req_valid = 2'b00;
        tick();
        #1 check("wd_no_capture_a", {32'd0, alu_a}, 64'd100);

        // Withdrawn port-1 pulse during RESP must not capture or move last_grant.
        req0_op = 4'h0; req0_a = 32'd40; req0_b = 32'd2; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        req1_op = 4'h4; req1_a = 32'hDEAD; req1_b = 32'hBEEF; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("wd_alu_a", {32'd0, alu_a}, 64'd40);
        check("wd_alu_op", {60'd0, alu_op}, 64'h0);
        req_valid = 2'b11;
        #1 check("wd_grant", {62'd0, req_ready}, 64'd2);
        req_valid = 2'b00;
        tick();

        // Reset during EXEC (with both valid: reset wins over the handshake).
        req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd2; req_valid = 2'b01;
        tick();
        rst = 1'b1; req_valid = 2'b11;
        tick();
        #1 check("rexec_ready", {62'd0, req_ready}, 64'd0);
        check_reset_outputs("rexec");
        rst = 1'b0; req_valid = 2'b00;
        tick();
        #1 check("rexec_no_rsp", {63'd0, rsp_valid}, 64'd0);
        tick();
        #1 check("rexec_no_rsp2", {63'd0, rsp_valid}, 64'd0);
        req_valid = 2'b11;
        #1 check("rexec_grant", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        tick();
        #1 check("rresp_rsp_valid", {63'd0, rsp_valid}, 64'd1);

        // Reset during RESP.
        rst = 1'b1;
        tick();
        #1 check_reset_outputs("rresp");
        rst = 1'b0;
        tick();
        #1 check("rresp_no_rsp", {63'd0, rsp_valid}, 64'd0);
        req_valid = 2'b11;
        #1 check("rresp_grant", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
